// File: rtl/zacore_fetch_if.sv
// Instruction-memory request/response bus between the Zacore fetch stage (master)
// and the instruction memory (slave).
interface zacore_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/zacore_fetch.sv
// Zacore RV32I fetch stage: PC, credit-based imem requests, tag/output FIFOs, redirect discard.
// Optional ZACORE_FETCH_SKID_EN doubles buffer depth (D=2) for full-rate fetch.
package zacore_fetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } datapath_info_t;

  typedef struct packed {
    datapath_info_t datapath_info;
  } execute_fetch_if_t;

  typedef struct packed {
    datapath_info_t datapath_info;
    logic [31:0]    inst;
  } fetch_decode_if_t;
endpackage

module zacore_fetch
  import zacore_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  execute_fetch_if_t execute_fetch_i,
  zacore_fetch_if.master    imem,
  output fetch_decode_if_t  fetch_decode_o,
  input  logic              decode_ready
);

`ifdef ZACORE_FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [31:0] pc_q;
  logic        run_q;
  cnt_t        inflight_q, discard_q, occ_q;
  ptr_t        tag_wr_q, tag_rd_q, out_wr_q, out_rd_q;

  logic [31:0] tag_mem      [DEPTH];
  logic [31:0] out_pc_mem   [DEPTH];
  logic [31:0] out_inst_mem [DEPTH];

  logic           redirect, out_valid, pop, req_fire, rsp, rsp_keep;
  logic [CNT_W:0] used;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    redirect  = execute_fetch_i.datapath_info.valid;
    out_valid = (occ_q != '0) && !redirect;
    pop       = out_valid && decode_ready;
    // Slots already promised (in flight + buffered), less the one decode frees now.
    used      = {1'b0, inflight_q} + {1'b0, occ_q} - {{CNT_W{1'b0}}, pop};

    imem.imem_req_valid = run_q && !redirect && (used < (CNT_W+1)'(DEPTH));
    imem.imem_req_addr  = pc_q;
    req_fire = imem.imem_req_valid && imem.imem_req_ready;
    rsp      = imem.imem_rsp_valid;
    rsp_keep = rsp && (discard_q == '0) && !redirect;

    fetch_decode_o = '0;
    if (out_valid) begin
      fetch_decode_o.datapath_info.valid = 1'b1;
      fetch_decode_o.datapath_info.pc    = out_pc_mem[out_rd_q];
      fetch_decode_o.inst                = out_inst_mem[out_rd_q];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      run_q      <= 1'b0;
      inflight_q <= '0;
      discard_q  <= '0;
      occ_q      <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
    end else begin
      run_q <= 1'b1;

      if (redirect)      pc_q <= {execute_fetch_i.datapath_info.pc[31:2], 2'b00};
      else if (req_fire) pc_q <= pc_q + 32'd4;

      if (req_fire) tag_wr_q <= ptr_inc(tag_wr_q);
      if (rsp)      tag_rd_q <= ptr_inc(tag_rd_q);
      inflight_q <= inflight_q + cnt_t'(req_fire) - cnt_t'(rsp);

      // Everything still outstanding after this cycle belongs to the old path.
      if (redirect)                       discard_q <= inflight_q - cnt_t'(rsp);
      else if (rsp && discard_q != '0)    discard_q <= discard_q - cnt_t'(1);

      if (redirect) begin
        occ_q    <= '0;
        out_wr_q <= '0;
        out_rd_q <= '0;
      end else begin
        if (rsp_keep) out_wr_q <= ptr_inc(out_wr_q);
        if (pop)      out_rd_q <= ptr_inc(out_rd_q);
        occ_q <= occ_q + cnt_t'(rsp_keep) - cnt_t'(pop);
      end
    end
  end

  // NOTE: FIFO storage is not reset; entries are only read behind a non-zero count
  // and the decode output is zero-gated while invalid.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_q] <= pc_q;
    if (rsp_keep) begin
      out_pc_mem[out_wr_q]   <= tag_mem[tag_rd_q];
      out_inst_mem[out_wr_q] <= imem.imem_rsp_data;
    end
  end

endmodule
